// File: rtl/decompressor_scheduler.sv
// decompressor_scheduler: round-robin, block-granular sharing of one decompressor between NUM_REQ word streams,
// with a channel-tagged byte return path.
module decompressor_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int CH_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [16*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]    req_cw_i,
    input  logic [NUM_REQ-1:0]    req_last_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [15:0]           dc_data_in_o,
    output logic                  dc_control_word_in_o,
    output logic                  dc_data_in_valid_o,
    input  logic                  dc_busy_i,
    input  logic [7:0]            dc_byte_i,
    input  logic                  dc_out_valid_i,
    output logic [7:0]            byte_out_o,
    output logic                  byte_out_valid_o,
    output logic [CH_W-1:0]       byte_out_chan_o,
    output logic                  block_done_o,
    output logic [CH_W-1:0]       block_done_chan_o,
    output logic                  timeout_err_o
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT} state_e;
    state_e              state_q;
    logic [CH_W-1:0]     rr_q, owner_q, out_owner_q, off_d, pick_d;
    logic                last_q, fire_d;
    logic [TW-1:0]       tcnt_q;
    logic [2*NUM_REQ-1:0] rot_d;
    logic [CH_W:0]       sum_d;
    // Rotate requests so bit 0 is rr_q, take the lowest set offset, then map back to a channel.
    always_comb begin
        rot_d = {req_valid_i, req_valid_i} >> rr_q;
        off_d = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) off_d = rot_d[i] ? CH_W'(i) : off_d;
        sum_d = {1'b0, rr_q} + {1'b0, off_d};
        pick_d = (sum_d >= (CH_W+1)'(NUM_REQ)) ? CH_W'(sum_d - (CH_W+1)'(NUM_REQ)) : sum_d[CH_W-1:0];
    end
    assign fire_d      = (state_q == ISSUE) && req_valid_i[owner_q];
    assign req_ready_o = fire_d ? (NUM_REQ'(1) << owner_q) : '0;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q              <= IDLE;
            rr_q                 <= '0;
            owner_q              <= '0;
            out_owner_q          <= '0;
            last_q               <= 1'b0;
            tcnt_q               <= '0;
            dc_data_in_o         <= '0;
            dc_control_word_in_o <= 1'b0;
            dc_data_in_valid_o   <= 1'b0;
            block_done_o         <= 1'b0;
            block_done_chan_o    <= '0;
            timeout_err_o        <= 1'b0;
        end else begin
            block_done_o <= 1'b0;
            case (state_q)
                IDLE: if (|req_valid_i) begin
                    owner_q <= pick_d;
                    state_q <= ISSUE;
                end
                ISSUE: if (fire_d) begin
                    dc_data_in_o         <= req_data_i[16*owner_q +: 16];
                    dc_control_word_in_o <= req_cw_i[owner_q];
                    last_q               <= req_last_i[owner_q];
                    out_owner_q          <= owner_q;
                    dc_data_in_valid_o   <= 1'b1;
                    tcnt_q               <= '0;
                    state_q              <= WAIT_ACK;
                end
                WAIT_ACK: if (dc_busy_i) begin
                    dc_data_in_valid_o <= 1'b0;
                    state_q            <= WAIT_DONE;
                end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
                    dc_data_in_valid_o <= 1'b0;
                    timeout_err_o      <= 1'b1;
                    state_q            <= NEXT;
                end else tcnt_q <= tcnt_q + 1'b1;
                WAIT_DONE: if (!dc_busy_i) state_q <= NEXT;
                NEXT: if (last_q) begin
                    block_done_o      <= 1'b1;
                    block_done_chan_o <= owner_q;
                    rr_q              <= (owner_q == CH_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_q           <= IDLE;
                end else state_q <= ISSUE;
                default: state_q <= IDLE;
            endcase
        end
    end
    // Byte return path runs independently of the issue FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_out_o       <= '0;
            byte_out_valid_o <= 1'b0;
            byte_out_chan_o  <= '0;
        end else begin
            byte_out_valid_o <= dc_out_valid_i;
            if (dc_out_valid_i) begin
                byte_out_o      <= dc_byte_i;
                byte_out_chan_o <= out_owner_q;
            end
        end
    end
endmodule

// File: tb/tb_decompressor_scheduler.sv
// tb_decompressor_scheduler: directed scenarios against a simple busy/byte model of the decompressor.
module tb_decompressor_scheduler;
    logic        clk = 0, rst_n = 0;
    logic [1:0]  req_valid = 0, req_cw = 0, req_last = 0, req_ready;
    logic [31:0] req_data = 0;
    logic [15:0] dc_data_in;
    logic        dc_cw, dc_valid, dc_busy, dc_out_valid;
    logic [7:0]  dc_byte, byte_out;
    logic        byte_out_valid, byte_out_chan, block_done, block_done_chan, timeout_err;
    logic        m_ov, t_ov = 0, never_busy = 0, prev_v = 0;
    logic [7:0]  m_byte, t_byte = 0;
    logic [1:0]  hold = 0;
    int          cnt, cyc = 0, errors = 0, checks = 0, onehot_bad = 0;
    logic [17:0] q0[$], q1[$];
    logic        iss_log[$], done_log[$];
    logic [16:0] din_log[$];
    logic [8:0]  bo_log[$];
    int          bo_cyc[$];

    assign dc_out_valid = m_ov | t_ov;
    assign dc_byte      = t_ov ? t_byte : m_byte;

    decompressor_scheduler dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_cw_i(req_cw), .req_last_i(req_last), .req_ready_o(req_ready),
        .dc_data_in_o(dc_data_in), .dc_control_word_in_o(dc_cw), .dc_data_in_valid_o(dc_valid),
        .dc_busy_i(dc_busy), .dc_byte_i(dc_byte), .dc_out_valid_i(dc_out_valid),
        .byte_out_o(byte_out), .byte_out_valid_o(byte_out_valid), .byte_out_chan_o(byte_out_chan),
        .block_done_o(block_done), .block_done_chan_o(block_done_chan), .timeout_err_o(timeout_err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decompressor model: busy for 4 cycles per accepted word, one byte (low byte of the word) per word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_busy <= 0; cnt <= 0; m_ov <= 0; m_byte <= 0;
        end else begin
            m_ov <= 0;
            if (cnt == 0) begin
                if (dc_valid && !never_busy) begin
                    dc_busy <= 1; cnt <= 4; m_byte <= dc_data_in[7:0];
                end
            end else begin
                cnt <= cnt - 1;
                if (cnt == 2) m_ov <= 1;
                if (cnt == 1) dc_busy <= 0;
            end
        end
    end

    // Requester model: each channel streams its queue; word = {data, cw, last}.
    always @(posedge clk) begin
        if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
        if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
        req_valid <= {(q1.size() != 0) && !hold[1], (q0.size() != 0) && !hold[0]};
        req_data  <= {q1.size() != 0 ? q1[0][17:2] : 16'h0, q0.size() != 0 ? q0[0][17:2] : 16'h0};
        req_cw    <= {q1.size() != 0 ? q1[0][1] : 1'b0, q0.size() != 0 ? q0[0][1] : 1'b0};
        req_last  <= {q1.size() != 0 ? q1[0][0] : 1'b0, q0.size() != 0 ? q0[0][0] : 1'b0};
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 0) begin
                if ((req_ready & (req_ready - 2'd1)) != 0) onehot_bad++;
                if ((req_valid & req_ready) != 0) iss_log.push_back(req_ready[1]);
            end
            if (dc_valid && !prev_v) din_log.push_back({dc_cw, dc_data_in});
            if (block_done) done_log.push_back(block_done_chan);
            if (byte_out_valid) begin
                bo_log.push_back({byte_out_chan, byte_out});
                bo_cyc.push_back(cyc);
            end
        end
        prev_v = dc_valid;
    end

    task automatic push(input int ch, input logic [15:0] d, input logic cw, input logic last);
        if (ch == 0) q0.push_back({d, cw, last}); else q1.push_back({d, cw, last});
    endtask

    task automatic clear_logs();
        iss_log.delete(); done_log.delete(); din_log.delete(); bo_log.delete(); bo_cyc.delete();
    endtask

    task automatic wait_blocks(input int n, input string nm);
        int k = 0;
        while (done_log.size() < n && k < 600) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        checks++;
        if (done_log.size() != n) begin
            errors++; $display("FAIL %s blocks: got %0d want %0d", nm, done_log.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, dc_data_in, dc_cw, dc_valid, byte_out, byte_out_valid, byte_out_chan,
             block_done, block_done_chan, timeout_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero, want all 0");
        end
        rst_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (timeout_err !== 0 || req_ready !== 0) begin
            errors++; $display("FAIL reset_idle: err=%b ready=%b want 0/00", timeout_err, req_ready);
        end
    endtask

    task automatic test_single();
        logic [16:0] exp [3] = '{17'h04142, 17'h04344, 17'h11003};
        logic [7:0]  eb [3] = '{8'h42, 8'h44, 8'h03};
        clear_logs();
        push(0, 16'h4142, 0, 0); push(0, 16'h4344, 0, 0); push(0, 16'h1003, 1, 1);
        wait_blocks(1, "single");
        checks++;
        if (iss_log.size() != 3) begin errors++; $display("FAIL single_issues: got %0d want 3", iss_log.size()); end
        for (int i = 0; i < 3 && i < din_log.size(); i++) begin
            checks++;
            if (din_log[i] !== exp[i]) begin errors++; $display("FAIL single_word%0d: got %h want %h", i, din_log[i], exp[i]); end
            checks++;
            if (iss_log.size() > i && iss_log[i] !== 1'b0) begin errors++; $display("FAIL single_chan%0d: got 1 want 0", i); end
        end
        checks++;
        if (done_log.size() > 0 && done_log[0] !== 1'b0) begin errors++; $display("FAIL single_done_chan: got 1 want 0"); end
        checks++;
        if (bo_log.size() != 3) begin errors++; $display("FAIL single_bytes: got %0d want 3", bo_log.size()); end
        for (int i = 0; i < 3 && i < bo_log.size(); i++) begin
            checks++;
            if (bo_log[i] !== {1'b0, eb[i]}) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, bo_log[i], {1'b0, eb[i]}); end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clear_logs();
        push(1, 16'h5151, 0, 0); push(1, 16'h5252, 0, 0); push(1, 16'h5353, 0, 1);
        while (!(dc_busy && !dc_valid) && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (dc_data_in !== 16'h5151) begin errors++; $display("FAIL midreset_pre: dc_data_in=%h want 5151", dc_data_in); end
        #2 rst_n = 0;
        #1 checks++;
        if ({req_ready, dc_data_in, dc_cw, dc_valid, byte_out, byte_out_valid, byte_out_chan,
             block_done, block_done_chan, timeout_err} !== '0) begin
            errors++; $display("FAIL midreset_async: outputs nonzero, want all 0");
        end
        q0.delete(); q1.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        clear_logs();
        repeat (10) @(negedge clk);
        checks++;
        if (done_log.size() != 0) begin errors++; $display("FAIL midreset_nodone: got %0d pulses want 0", done_log.size()); end
        push(0, 16'h0101, 0, 1); push(1, 16'h0202, 0, 1);
        wait_blocks(2, "midreset_rr");
        checks++;
        if (iss_log.size() > 0 && iss_log[0] !== 1'b0) begin errors++; $display("FAIL midreset_rr0: first grant ch1 want ch0"); end
    endtask

    task automatic test_round_robin();
        clear_logs();
        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 2; c++) begin
                push(c, 16'(c * 16'h1000 + b * 2), 0, 0);
                push(c, 16'(c * 16'h1000 + b * 2 + 1), 1, 1);
            end
        wait_blocks(6, "rr");
        checks++;
        if (iss_log.size() != 12) begin errors++; $display("FAIL rr_issues: got %0d want 12", iss_log.size()); end
        for (int i = 0; i < 12 && i < iss_log.size(); i++) begin
            checks++;
            if (iss_log[i] !== 1'((i / 2) % 2)) begin errors++; $display("FAIL rr_issue%0d: got %b want %0d", i, iss_log[i], (i / 2) % 2); end
        end
        for (int i = 0; i < 6 && i < done_log.size(); i++) begin
            checks++;
            if (done_log[i] !== 1'(i % 2)) begin errors++; $display("FAIL rr_done%0d: got %b want %0d", i, done_log[i], i % 2); end
        end
    endtask

    task automatic test_hold();
        int k = 0, bad = 0;
        logic exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        clear_logs();
        push(1, 16'h6161, 0, 0); push(1, 16'h6262, 0, 0); push(1, 16'h6363, 1, 1);
        while (iss_log.size() == 0 && k < 100) begin @(negedge clk); k++; end
        hold[1] = 1;
        push(0, 16'h0A0A, 0, 1);
        repeat (18) begin
            @(negedge clk);
            if (req_ready !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0 || iss_log.size() != 1) begin
            errors++; $display("FAIL hold_locked: ready cycles=%0d issues=%0d want 0/1", bad, iss_log.size());
        end
        hold[1] = 0;
        wait_blocks(2, "hold");
        for (int i = 0; i < 4 && i < iss_log.size(); i++) begin
            checks++;
            if (iss_log[i] !== exp[i]) begin errors++; $display("FAIL hold_issue%0d: got %b want %b", i, iss_log[i], exp[i]); end
        end
        checks++;
        if (done_log.size() == 2 && (done_log[0] !== 1'b1 || done_log[1] !== 1'b0)) begin
            errors++; $display("FAIL hold_done: got %b%b want 10", done_log[0], done_log[1]);
        end
    endtask

    task automatic test_timeout();
        int k = 0, vc = 0;
        clear_logs();
        never_busy = 1;
        push(1, 16'h7777, 0, 1);
        while (done_log.size() == 0 && k < 200) begin
            @(negedge clk); k++;
            if (dc_valid) vc++;
        end
        checks++;
        if (vc != 16) begin errors++; $display("FAIL timeout_len: valid cycles=%0d want 16", vc); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", timeout_err); end
        checks++;
        if (done_log.size() != 1 || done_log[0] !== 1'b1) begin errors++; $display("FAIL timeout_advance: blocks=%0d want 1 on ch1", done_log.size()); end
        never_busy = 0;
        clear_logs();
        push(1, 16'h1234, 1, 1);
        wait_blocks(1, "timeout_next");
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_back_to_back();
        int c0;
        clear_logs();
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            t_ov = 1; t_byte = 8'h61 + 8'(i);
            @(negedge clk);
        end
        t_ov = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bo_log.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", bo_log.size()); end
        for (int i = 0; i < 6 && i < bo_log.size(); i++) begin
            checks++;
            if (bo_log[i] !== {1'b1, 8'h61 + 8'(i)} || bo_cyc[i] != c0 + 1 + i) begin
                errors++; $display("FAIL b2b_byte%0d: got %h at %0d want %h at %0d", i, bo_log[i], bo_cyc[i], {1'b1, 8'h61 + 8'(i)}, c0 + 1 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_hold();
        test_timeout();
        test_back_to_back();
        checks++;
        if (onehot_bad != 0) begin errors++; $display("FAIL ready_onehot: violations=%0d want 0", onehot_bad); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
